rle_enc_p: RTL
==============

Name: rle_enc_p

Overview:
- Parametrised run-length encoder for the frame-processing datapath.
- Reads a plaintext frame from single-port SRAM port A and emits {symbol,count} pairs packed into DATA_W words at rle_addr.
- Reports compressed length in bytes and pulses done.
- Generalises symbol width, word width, read latency and maximum run length; runs longer than the count field are split automatically.

Parameters:
- DATA_W, 32, SRAM word width; multiple of 2*SYM_W.
- SYM_W, 8, symbol width; multiple of 8; count field is also SYM_W.
- ADDR_W, 16, SRAM word-address width.
- RD_LAT, 1, cycles from address (we=0) to valid port_A_data_out; range 1..3.

Ports:
- clk  in  1  clock; also drives port_A_clk.
- nreset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse; accepted only in IDLE.
- message_addr  in  ADDR_W  first plaintext word address.
- message_size  in  32  plaintext length in bytes; floored to a whole number of symbols.
- rle_addr  in  ADDR_W  first output word address.
- rle_size  out  32  compressed length in bytes; valid when done=1.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from start acceptance until done.
- port_A_clk  out  1  equals clk.
- port_A_addr  out  ADDR_W  SRAM word address.
- port_A_we  out  1  write enable.
- port_A_data_in  out  DATA_W  write data.
- port_A_data_out  in  DATA_W  read data.

Behaviour:
- Reset: state=IDLE; rle_size=0, done=0, busy=0, port_A_we=0, port_A_addr=0, port_A_data_in=0; run and pack registers cleared.
- Symbol order: symbol k of a word is bits [k*SYM_W +: SYM_W]; lane 0 is consumed first. The same rule applies to pair packing: pair j occupies [j*2*SYM_W +: 2*SYM_W], with symbol in the low half and count in the high half.
- FSM states: IDLE, RD_REQ, RD_WAIT, SCAN, WR, FLUSH, FIN.
- IDLE + start:
  - latch addresses and nsym = message_size/(SYM_W/8);
  - clear run_cnt, pack_idx, rle_size;
  - busy<=1.
  - If nsym=0, go to FIN. Otherwise go to RD_REQ.
- RD_REQ: drive the read address, we=0 -> RD_WAIT, which lasts RD_LAT cycles -> SCAN. The word is latched on entry to SCAN.
- SCAN: processes one symbol per cycle, skipping lanes beyond nsym in the last word.
  - First symbol of the frame: run_sym=sym, run_cnt=1.
  - sym==run_sym and run_cnt < 2^SYM_W-1: run_cnt++.
  - Otherwise emit {run_sym,run_cnt} into lane pack_idx, then restart the run with sym.
  - A saturated run is therefore emitted as a max-count pair and continues with count 1.
  - When the word is exhausted: go to RD_REQ if symbols remain, else FLUSH.
- Emit: rle_size += 2*SYM_W/8 per pair. When pack_idx wraps (word full), go to WR.
- WR: one cycle with we=1 at rle_addr+wr_idx; then wr_idx++, clear the pack register, return to SCAN.
- FLUSH:
  - emit the pending run;
  - if pack_idx != 0, write the partial word with unused lanes zeroed;
  - -> FIN.
- FIN: done=1 for one cycle, busy<=0, we=0 -> IDLE. rle_size holds until the next start.
- start while busy: ignored.
- Address arithmetic wraps modulo 2^ADDR_W. Overlapping source and destination regions are not supported.
- nreset mid-frame: immediate return to reset values. A write in flight is abandoned with we=0.
- rle_size never exceeds 2*message_size.

Optional Feature:
- RLE_ABORT_EN defined:
  - adds input abort (1 bit);
  - abort while busy -> next cycle we=0, done pulses, rle_size holds the bytes already written, FSM returns to IDLE;
  - abort takes priority over a simultaneous WR;
  - abort in IDLE is ignored.
- Undefined: no abort port; every frame runs to completion.

Decomposition:
- Package rle_pkg holds:
  - state enum;
  - localparams SYM_PER_WORD = DATA_W/SYM_W, PAIRS_PER_WORD = DATA_W/(2*SYM_W), MAX_RUN = 2^SYM_W-1;
  - byte-per-pair constant.
- Sub-module rle_packer: pair accumulator with lane index, full flag, flush and clear. It isolates the packing logic from the scan FSM.

Test Plan:
- Defaults; 8 bytes "AAAABBBC" -> words {A,4,B,3} and {C,1,0,0} (lane order low-first), rle_size=6, done 1 cycle.
- 300 bytes of 0x55 -> pairs (55,255),(55,45), rle_size=4, one word written.
- message_size=0 -> no SRAM access, done within 2 cycles, rle_size=0.
- SYM_W=16, DATA_W=64, RD_LAT=2, 6 alternating symbols -> six pairs over 3 words, rle_size=24, reads spaced by latency.
- nreset asserted mid-WR, then a new start with 4 bytes "ZZZZ" -> clean output {Z,4}, rle_size=2.
- RLE_ABORT_EN, abort after the first word write -> done pulse, rle_size=4, no further writes.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types for the run-length encoder: FSM state encoding and lane-geometry helpers
// used by the scan FSM and the pair packer.
package rle_pkg;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SCAN, WR, FLUSH, FIN} state_t;

  function automatic int sym_per_word(input int data_w, input int sym_w);
    return data_w / sym_w;
  endfunction

  function automatic int pairs_per_word(input int data_w, input int sym_w);
    return data_w / (2 * sym_w);
  endfunction

  function automatic int bytes_per_pair(input int sym_w);
    return (2 * sym_w) / 8;
  endfunction

endpackage

// File: rtl/rle_packer.sv
// Accumulates {symbol,count} pairs into an output word, lane 0 first, and reports when the
// next push completes the word; a completing push hands the word out and self-clears.
module rle_packer
  import rle_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SYM_W  = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              clear,
  input  logic              push,
  input  logic [SYM_W-1:0]  sym,
  input  logic [SYM_W-1:0]  cnt,
  output logic [DATA_W-1:0] word_next,
  output logic              last_lane
);

  localparam int PPW   = pairs_per_word(DATA_W, SYM_W);
  localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;

  logic [DATA_W-1:0] pack;
  logic [IDX_W-1:0]  idx;

  // word_next is the pack register with the incoming pair merged in; unused lanes stay zero
  always_comb begin
    word_next = pack;
    for (int j = 0; j < PPW; j++)
      if (idx == IDX_W'(j)) word_next[j*2*SYM_W +: 2*SYM_W] = {cnt, sym};
  end

  assign last_lane = (idx == IDX_W'(PPW - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pack <= '0;
      idx  <= '0;
    end else if (clear) begin
      pack <= '0;
      idx  <= '0;
    end else if (push) begin
      if (last_lane) begin
        pack <= '0;
        idx  <= '0;
      end else begin
        pack <= word_next;
        idx  <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/rle_enc_p.sv
// Run-length encoder: reads a frame from SRAM port A and writes packed {symbol,count} pairs
// back through the same port. Optional abort input is enabled by defining RLE_ABORT_EN.
module rle_enc_p
  import rle_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SYM_W  = 8,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [31:0]       message_size,
  input  logic [ADDR_W-1:0] rle_addr,
`ifdef RLE_ABORT_EN
  input  logic              abort,
`endif
  output logic [31:0]       rle_size,
  output logic              done,
  output logic              busy,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [DATA_W-1:0] port_A_data_in,
  input  logic [DATA_W-1:0] port_A_data_out
);

  localparam int SPW       = sym_per_word(DATA_W, SYM_W);
  localparam int BPP       = bytes_per_pair(SYM_W);
  localparam int BPW       = DATA_W / 8;
  localparam int SYM_BYTES = SYM_W / 8;
  localparam int LANE_W    = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [SYM_W-1:0] MAX_RUN = '1;

  state_t            state, resume;
  logic [ADDR_W-1:0] rd_addr, base_addr, wr_idx;
  logic [31:0]       sym_left, nsym;
  logic [LANE_W-1:0] lane;
  logic [DATA_W-1:0] word;
  logic [SYM_W-1:0]  run_sym, run_cnt, sym;
  logic [1:0]        wait_cnt;
  logic              first_sym, extend, word_end, push, pack_clear, last_lane, abort_hit;
  logic [DATA_W-1:0] pack_word;

  assign port_A_clk = clk;

  always_comb begin
    sym = '0;
    for (int k = 0; k < SPW; k++)
      if (lane == LANE_W'(k)) sym = word[k*SYM_W +: SYM_W];
  end

  assign nsym       = message_size / 32'(SYM_BYTES);
  assign first_sym  = (run_cnt == '0);
  assign extend     = (sym == run_sym) && (run_cnt != MAX_RUN);
  assign word_end   = (lane == LANE_W'(SPW - 1)) || (sym_left == 32'd1);
  assign push       = !abort_hit && ((state == SCAN && !first_sym && !extend) || state == FLUSH);
  assign pack_clear = (state == IDLE) && start;

`ifdef RLE_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  rle_packer #(.DATA_W(DATA_W), .SYM_W(SYM_W)) u_packer (
    .clk       (clk),
    .nreset    (nreset),
    .clear     (pack_clear),
    .push      (push),
    .sym       (run_sym),
    .cnt       (run_cnt),
    .word_next (pack_word),
    .last_lane (last_lane)
  );

  // The SRAM address is loaded on the edge entering RD_REQ so RD_WAIT covers exactly RD_LAT cycles
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state          <= IDLE;
      resume         <= IDLE;
      rle_size       <= '0;
      done           <= 1'b0;
      busy           <= 1'b0;
      port_A_we      <= 1'b0;
      port_A_addr    <= '0;
      port_A_data_in <= '0;
      rd_addr        <= '0;
      base_addr      <= '0;
      wr_idx         <= '0;
      sym_left       <= '0;
      lane           <= '0;
      word           <= '0;
      run_sym        <= '0;
      run_cnt        <= '0;
      wait_cnt       <= '0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state     <= IDLE;
        port_A_we <= 1'b0;
        done      <= 1'b1;
        busy      <= 1'b0;
        rle_size  <= 32'(wr_idx) * 32'(BPW);
      end else begin
        case (state)
          IDLE: if (start) begin
            base_addr <= rle_addr;
            wr_idx    <= '0;
            run_cnt   <= '0;
            rle_size  <= '0;
            busy      <= 1'b1;
            sym_left  <= nsym;
            if (nsym == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state       <= RD_REQ;
              port_A_addr <= message_addr;
              rd_addr     <= message_addr + ADDR_W'(1);
            end
          end
          RD_REQ: begin
            wait_cnt <= 2'(RD_LAT - 1);
            state    <= RD_WAIT;
          end
          RD_WAIT: begin
            if (wait_cnt == '0) begin
              word  <= port_A_data_out;
              lane  <= '0;
              state <= SCAN;
            end else begin
              wait_cnt <= wait_cnt - 2'd1;
            end
          end
          SCAN: begin
            sym_left <= sym_left - 32'd1;
            lane     <= lane + LANE_W'(1);
            if (first_sym || !extend) begin
              run_sym <= sym;
              run_cnt <= SYM_W'(1);
            end else begin
              run_cnt <= run_cnt + SYM_W'(1);
            end
            if (push) rle_size <= rle_size + 32'(BPP);
            if (push && last_lane) begin
              state          <= WR;
              port_A_we      <= 1'b1;
              port_A_data_in <= pack_word;
              port_A_addr    <= base_addr + wr_idx;
              resume         <= !word_end ? SCAN : (sym_left == 32'd1) ? FLUSH : RD_REQ;
            end else if (word_end) begin
              if (sym_left == 32'd1) begin
                state <= FLUSH;
              end else begin
                state       <= RD_REQ;
                port_A_addr <= rd_addr;
                rd_addr     <= rd_addr + ADDR_W'(1);
              end
            end
          end
          WR: begin
            port_A_we <= 1'b0;
            wr_idx    <= wr_idx + ADDR_W'(1);
            state     <= resume;
            if (resume == RD_REQ) begin
              port_A_addr <= rd_addr;
              rd_addr     <= rd_addr + ADDR_W'(1);
            end
            if (resume == FIN) done <= 1'b1;
          end
          // The pending run always yields one more pair, so the last word is always written
          FLUSH: begin
            rle_size       <= rle_size + 32'(BPP);
            port_A_we      <= 1'b1;
            port_A_data_in <= pack_word;
            port_A_addr    <= base_addr + wr_idx;
            resume         <= FIN;
            state          <= WR;
          end
          FIN: begin
            busy      <= 1'b0;
            port_A_we <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
